rv32i_encoder: RTL
==================

# rv32i_encoder

Streaming RV32I instruction encoder, the producer-side counterpart of the front-end decoder. Accepts one symbolic instruction per handshake (mnemonic plus register and immediate fields), range-checks it, packs it into a 32-bit machine word, and emits it with its program address. It generates instruction streams and program images for the decoder and core benches, and serves as a self-check reference when decoded fields are round-tripped back through the decoder.

## Interface
- `PC_RESET`, default 32'h0000_0000: address assigned to the first emitted word.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: input instruction valid.
- `in_ready`  out  1: encoder can accept; 0 while `rst` is high.
- `in_mnemonic`  in  `mnemonic_t`: instruction from the `fe_pkg` mnemonic enum.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each: register indices; ignored where the format has no such field.
- `in_imm`  in  32: signed byte-offset or immediate value.
- `out_valid`  out  1: encoded word valid.
- `out_ready`  in  1: consumer accepts the word.
- `out_bits`  out  `RV32I_INSTRUCTION_WIDTH`: encoded machine word.
- `out_pc`  out  32: address of `out_bits`.
- `out_illegal`  out  1: the word came from an out-of-range or unsupported input.
- `illegal_count`  out  16: saturating count of illegal words emitted.

## Operation
- Input transfer when `in_valid && in_ready`. Output transfer when `out_valid && out_ready`.
- Formats follow the RV32I base ISA. The `fe_pkg` format lookup maps each mnemonic to opcode, funct3, funct7 and format (R/I/S/B/U/J/SYS).
- Immediate legality rules:
  - I and S: -2048..2047.
  - Shift-immediate (SLLI/SRLI/SRAI): 0..31. SRAI sets funct7 = 0100000.
  - B: -4096..4094, and the value must be even.
  - J: -1048576..1048574, and the value must be even.
  - U: `in_imm[11:0]` must be 0; bits [31:12] are placed directly.
  - SYS (ECALL/EBREAK): fixed words; all fields are ignored.
- Illegal input (range violation or a mnemonic with no encoding):
  - `out_bits` = 32'h0000_0000.
  - `out_illegal` = 1.
  - The word still consumes a PC slot.
  - `illegal_count` increments on output transfer and saturates at 16'hFFFF.
- `out_pc` starts at `PC_RESET` and advances by 4 after each output transfer. It wraps modulo 2^32 with no flag.

## Timing
- Latency is 1 cycle. Input accepted at edge N is presented at `out_*` after edge N (visible in cycle N+1) if the output register is empty or drains at edge N.
- Buffering is an output register plus a one-entry skid buffer, giving full throughput of one word per cycle under continuous `out_ready`.
- `in_ready` = skid buffer empty. It is registered, so there is no combinational path from `out_ready`.
- States: EMPTY, ONE (output register valid), TWO (output register and skid valid).
  - EMPTY → ONE on input transfer.
  - ONE → TWO on input transfer without output transfer.
  - TWO → ONE on output transfer; the skid entry moves into the output register.
  - ONE → EMPTY on output transfer without input transfer.
  - ONE with simultaneous input and output transfer: stays ONE and loads the new word.
- Ordering is strictly FIFO. `out_bits`, `out_pc` and `out_illegal` hold stable while `out_valid && !out_ready`.
- Reset values (applies in any state, including mid-stream):
  - `out_valid` = 0, `out_bits` = 0, `out_illegal` = 0.
  - `out_pc` = `PC_RESET`, `illegal_count` = 0, `in_ready` = 0.
  - State = EMPTY, and the skid contents are discarded.
  - `in_ready` rises to 1 in the first cycle after `rst` deasserts.

## Structure
- Shared package `fe_pkg` holds:
  - `mnemonic_t` and `opcode_t`.
  - The format enum `fmt_t` (R, I, S, B, U, J, SYS).
  - Per-mnemonic funct3/funct7 constants and the format lookup function.
- The decoder and the encoder both use this package, so neither has a private opcode table.
- Sub-module `rv32i_field_packer` is purely combinational: mnemonic, register fields and imm in; word plus illegal flag out. It is instantiated once, in front of the skid/output stage.
- `rv32i_encoder` contains the handshake FSM, skid buffer, PC counter and illegal counter.

## Test plan
- Field encoding, one word per cycle, `out_ready` = 1:
  - ADDI x1,x0,5 → 0x00500093.
  - ADD x3,x1,x2 → 0x002081B3.
  - SW x2,8(x1) → 0x0020A423.
  - `out_pc` reads 0x0, 0x4, 0x8.
- Control flow and upper-immediate encoding:
  - BEQ x1,x2,+16 → 0x00208863.
  - JAL x1,+2048 → 0x001000EF.
  - LUI x5,0x12345000 → 0x123452B7.
- Illegal inputs:
  - ADDI imm 2048 → `out_bits` 0, `out_illegal` 1, `illegal_count` 1.
  - BEQ imm 7 → illegal.
  - SLLI imm 32 → illegal.
  - In all three cases `out_pc` still advances.
- Back-pressure:
  - Hold `out_ready` = 0 with `in_valid` continuously high.
  - Exactly 2 words are accepted, then `in_ready` = 0 and the outputs stay stable.
  - Release `out_ready`: words drain in order with no loss or duplication.
- Reset mid-stream:
  - Assert `rst` in state TWO → next cycle `out_valid` = 0, `out_pc` = `PC_RESET`, `illegal_count` = 0.
  - The first word after reset carries `PC_RESET`.
- Round trip: stream all base mnemonics through the encoder into the decoder; the decoded mnemonic and fields must equal the inputs.

Source files
------------

// File: rtl/fe_pkg.sv
// Front-end shared package: RV32I mnemonics, opcodes, formats, funct codes
// and the per-mnemonic format lookup used by both encoder and decoder.
package fe_pkg;

    localparam int unsigned RV32I_INSTRUCTION_WIDTH = 32;
    localparam int unsigned REG_IDX_W               = 5;
    localparam int unsigned ILLEGAL_CNT_W           = 16;

    typedef enum logic [5:0] {
        MN_LUI, MN_AUIPC, MN_JAL, MN_JALR,
        MN_BEQ, MN_BNE, MN_BLT, MN_BGE, MN_BLTU, MN_BGEU,
        MN_LB, MN_LH, MN_LW, MN_LBU, MN_LHU,
        MN_SB, MN_SH, MN_SW,
        MN_ADDI, MN_SLTI, MN_SLTIU, MN_XORI, MN_ORI, MN_ANDI,
        MN_SLLI, MN_SRLI, MN_SRAI,
        MN_ADD, MN_SUB, MN_SLL, MN_SLT, MN_SLTU, MN_XOR, MN_SRL, MN_SRA, MN_OR, MN_AND,
        MN_FENCE, MN_ECALL, MN_EBREAK
    } mnemonic_t;

    typedef enum logic [6:0] {
        OP_LUI      = 7'b0110111,
        OP_AUIPC    = 7'b0010111,
        OP_JAL      = 7'b1101111,
        OP_JALR     = 7'b1100111,
        OP_BRANCH   = 7'b1100011,
        OP_LOAD     = 7'b0000011,
        OP_STORE    = 7'b0100011,
        OP_IMM      = 7'b0010011,
        OP_REG      = 7'b0110011,
        OP_MISC_MEM = 7'b0001111,
        OP_SYSTEM   = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS, FMT_NONE
    } fmt_t;

    typedef enum logic [1:0] {
        ST_EMPTY, ST_ONE, ST_TWO
    } enc_state_t;

    localparam logic [6:0]  F7_BASE     = 7'b0000000;
    localparam logic [6:0]  F7_ALT      = 7'b0100000;
    localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;
    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

    // Static encoding attributes of one mnemonic.
    typedef struct packed {
        fmt_t       fmt;
        opcode_t    opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       is_shift;
    } enc_info_t;

    function automatic enc_info_t mk_info(fmt_t f, opcode_t op, logic [2:0] f3,
                                          logic [6:0] f7, logic sh);
        enc_info_t info;
        info.fmt      = f;
        info.opcode   = op;
        info.funct3   = f3;
        info.funct7   = f7;
        info.is_shift = sh;
        return info;
    endfunction

    function automatic enc_info_t fmt_lookup(mnemonic_t mn);
        enc_info_t info;
        info = mk_info(FMT_NONE, OP_IMM, 3'd0, F7_BASE, 1'b0);
        case (mn)
            MN_LUI:    info = mk_info(FMT_U,   OP_LUI,      3'd0, F7_BASE, 1'b0);
            MN_AUIPC:  info = mk_info(FMT_U,   OP_AUIPC,    3'd0, F7_BASE, 1'b0);
            MN_JAL:    info = mk_info(FMT_J,   OP_JAL,      3'd0, F7_BASE, 1'b0);
            MN_JALR:   info = mk_info(FMT_I,   OP_JALR,     3'd0, F7_BASE, 1'b0);
            MN_BEQ:    info = mk_info(FMT_B,   OP_BRANCH,   3'd0, F7_BASE, 1'b0);
            MN_BNE:    info = mk_info(FMT_B,   OP_BRANCH,   3'd1, F7_BASE, 1'b0);
            MN_BLT:    info = mk_info(FMT_B,   OP_BRANCH,   3'd4, F7_BASE, 1'b0);
            MN_BGE:    info = mk_info(FMT_B,   OP_BRANCH,   3'd5, F7_BASE, 1'b0);
            MN_BLTU:   info = mk_info(FMT_B,   OP_BRANCH,   3'd6, F7_BASE, 1'b0);
            MN_BGEU:   info = mk_info(FMT_B,   OP_BRANCH,   3'd7, F7_BASE, 1'b0);
            MN_LB:     info = mk_info(FMT_I,   OP_LOAD,     3'd0, F7_BASE, 1'b0);
            MN_LH:     info = mk_info(FMT_I,   OP_LOAD,     3'd1, F7_BASE, 1'b0);
            MN_LW:     info = mk_info(FMT_I,   OP_LOAD,     3'd2, F7_BASE, 1'b0);
            MN_LBU:    info = mk_info(FMT_I,   OP_LOAD,     3'd4, F7_BASE, 1'b0);
            MN_LHU:    info = mk_info(FMT_I,   OP_LOAD,     3'd5, F7_BASE, 1'b0);
            MN_SB:     info = mk_info(FMT_S,   OP_STORE,    3'd0, F7_BASE, 1'b0);
            MN_SH:     info = mk_info(FMT_S,   OP_STORE,    3'd1, F7_BASE, 1'b0);
            MN_SW:     info = mk_info(FMT_S,   OP_STORE,    3'd2, F7_BASE, 1'b0);
            MN_ADDI:   info = mk_info(FMT_I,   OP_IMM,      3'd0, F7_BASE, 1'b0);
            MN_SLTI:   info = mk_info(FMT_I,   OP_IMM,      3'd2, F7_BASE, 1'b0);
            MN_SLTIU:  info = mk_info(FMT_I,   OP_IMM,      3'd3, F7_BASE, 1'b0);
            MN_XORI:   info = mk_info(FMT_I,   OP_IMM,      3'd4, F7_BASE, 1'b0);
            MN_ORI:    info = mk_info(FMT_I,   OP_IMM,      3'd6, F7_BASE, 1'b0);
            MN_ANDI:   info = mk_info(FMT_I,   OP_IMM,      3'd7, F7_BASE, 1'b0);
            MN_SLLI:   info = mk_info(FMT_I,   OP_IMM,      3'd1, F7_BASE, 1'b1);
            MN_SRLI:   info = mk_info(FMT_I,   OP_IMM,      3'd5, F7_BASE, 1'b1);
            MN_SRAI:   info = mk_info(FMT_I,   OP_IMM,      3'd5, F7_ALT,  1'b1);
            MN_ADD:    info = mk_info(FMT_R,   OP_REG,      3'd0, F7_BASE, 1'b0);
            MN_SUB:    info = mk_info(FMT_R,   OP_REG,      3'd0, F7_ALT,  1'b0);
            MN_SLL:    info = mk_info(FMT_R,   OP_REG,      3'd1, F7_BASE, 1'b0);
            MN_SLT:    info = mk_info(FMT_R,   OP_REG,      3'd2, F7_BASE, 1'b0);
            MN_SLTU:   info = mk_info(FMT_R,   OP_REG,      3'd3, F7_BASE, 1'b0);
            MN_XOR:    info = mk_info(FMT_R,   OP_REG,      3'd4, F7_BASE, 1'b0);
            MN_SRL:    info = mk_info(FMT_R,   OP_REG,      3'd5, F7_BASE, 1'b0);
            MN_SRA:    info = mk_info(FMT_R,   OP_REG,      3'd5, F7_ALT,  1'b0);
            MN_OR:     info = mk_info(FMT_R,   OP_REG,      3'd6, F7_BASE, 1'b0);
            MN_AND:    info = mk_info(FMT_R,   OP_REG,      3'd7, F7_BASE, 1'b0);
            MN_FENCE:  info = mk_info(FMT_I,   OP_MISC_MEM, 3'd0, F7_BASE, 1'b0);
            MN_ECALL:  info = mk_info(FMT_SYS, OP_SYSTEM,   3'd0, F7_BASE, 1'b0);
            MN_EBREAK: info = mk_info(FMT_SYS, OP_SYSTEM,   3'd0, F7_BASE, 1'b0);
            default:   info = mk_info(FMT_NONE, OP_IMM,     3'd0, F7_BASE, 1'b0);
        endcase
        return info;
    endfunction

endpackage

// File: rtl/rv32i_field_packer.sv
// Combinational RV32I field packer: range-checks the immediate for the
// mnemonic's format and assembles the 32-bit word (zero when illegal).
// Ports: mnemonic_i, rd_i, rs1_i, rs2_i, imm_i in; word_c_o, illegal_c_o out.
module rv32i_field_packer
    import fe_pkg::*;
(
    input  mnemonic_t                            mnemonic_i,
    input  logic [REG_IDX_W-1:0]                 rd_i,
    input  logic [REG_IDX_W-1:0]                 rs1_i,
    input  logic [REG_IDX_W-1:0]                 rs2_i,
    input  logic [31:0]                          imm_i,
    output logic [RV32I_INSTRUCTION_WIDTH-1:0]   word_c_o,
    output logic                                 illegal_c_o
);

    enc_info_t  info;
    logic       legal;
    logic [31:0] word;
    logic       fits12;
    logic       fits13;
    logic       fits21;

    // Signed N-bit fit: all bits above the sign bit equal to it.
    assign fits12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign fits13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
    assign fits21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);
    assign info   = fmt_lookup(mnemonic_i);

    always_comb begin
        legal = 1'b0;
        word  = '0;
        case (info.fmt)
            FMT_R: begin
                legal = 1'b1;
                word  = {info.funct7, rs2_i, rs1_i, info.funct3, rd_i, info.opcode};
            end
            FMT_I: begin
                if (info.is_shift) begin
                    legal = ~(|imm_i[31:5]);
                    word  = {info.funct7, imm_i[4:0], rs1_i, info.funct3, rd_i, info.opcode};
                end else begin
                    legal = fits12;
                    word  = {imm_i[11:0], rs1_i, info.funct3, rd_i, info.opcode};
                end
            end
            FMT_S: begin
                legal = fits12;
                word  = {imm_i[11:5], rs2_i, rs1_i, info.funct3, imm_i[4:0], info.opcode};
            end
            FMT_B: begin
                legal = fits13 & ~imm_i[0];
                word  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, info.funct3,
                         imm_i[4:1], imm_i[11], info.opcode};
            end
            FMT_U: begin
                legal = ~(|imm_i[11:0]);
                word  = {imm_i[31:12], rd_i, info.opcode};
            end
            FMT_J: begin
                legal = fits21 & ~imm_i[0];
                word  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, info.opcode};
            end
            FMT_SYS: begin
                legal = 1'b1;
                word  = (mnemonic_i == MN_EBREAK) ? EBREAK_WORD : ECALL_WORD;
            end
            default: begin
                legal = 1'b0;
                word  = '0;
            end
        endcase
        word_c_o    = legal ? word : '0;
        illegal_c_o = ~legal;
    end

endmodule

// File: rtl/rv32i_encoder.sv
// Streaming RV32I encoder: packer in front of an output register plus a
// one-entry skid buffer, with program-address and illegal-word counters.
// Ports: clk, rst (sync, active high); in_* input handshake and fields;
// out_* output handshake, word, address, illegal flag; illegal_count.
module rv32i_encoder
    import fe_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  mnemonic_t                            in_mnemonic,
    input  logic [REG_IDX_W-1:0]                 in_rd,
    input  logic [REG_IDX_W-1:0]                 in_rs1,
    input  logic [REG_IDX_W-1:0]                 in_rs2,
    input  logic [31:0]                          in_imm,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [RV32I_INSTRUCTION_WIDTH-1:0]   out_bits,
    output logic [31:0]                          out_pc,
    output logic                                 out_illegal,
    output logic [ILLEGAL_CNT_W-1:0]             illegal_count
);

    enc_state_t                           state_q, state_d;
    logic                                 in_fire, out_fire;
    logic                                 load_out_in, load_out_skid, load_skid;
    logic [RV32I_INSTRUCTION_WIDTH-1:0]   pack_word;
    logic                                 pack_illegal;

    logic                                 out_valid_q, in_ready_q;
    logic [RV32I_INSTRUCTION_WIDTH-1:0]   out_bits_q, skid_bits_q;
    logic                                 out_illegal_q, skid_illegal_q;
    logic [31:0]                          out_pc_q;
    logic [ILLEGAL_CNT_W-1:0]             illegal_count_q;

    rv32i_field_packer u_packer (
        .mnemonic_i  (in_mnemonic),
        .rd_i        (in_rd),
        .rs1_i       (in_rs1),
        .rs2_i       (in_rs2),
        .imm_i       (in_imm),
        .word_c_o    (pack_word),
        .illegal_c_o (pack_illegal)
    );

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (in_fire) state_d = ST_ONE;
            ST_ONE: begin
                if (in_fire && !out_fire)      state_d = ST_TWO;
                else if (!in_fire && out_fire) state_d = ST_EMPTY;
            end
            ST_TWO:   if (out_fire) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Datapath load controls.
    always_comb begin
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            ST_EMPTY: load_out_in = in_fire;
            ST_ONE: begin
                load_out_in = in_fire & out_fire;
                load_skid   = in_fire & ~out_fire;
            end
            ST_TWO:   load_out_skid = out_fire;
            default: ;
        endcase
    end

    // Output register, skid entry and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q     <= 1'b0;
            in_ready_q      <= 1'b0;
            out_bits_q      <= '0;
            out_illegal_q   <= 1'b0;
            skid_bits_q     <= '0;
            skid_illegal_q  <= 1'b0;
            out_pc_q        <= PC_RESET;
            illegal_count_q <= '0;
        end else begin
            out_valid_q <= (state_d != ST_EMPTY);
            in_ready_q  <= (state_d != ST_TWO);
            if (load_out_in) begin
                out_bits_q    <= pack_word;
                out_illegal_q <= pack_illegal;
            end else if (load_out_skid) begin
                out_bits_q    <= skid_bits_q;
                out_illegal_q <= skid_illegal_q;
            end
            if (load_skid) begin
                skid_bits_q    <= pack_word;
                skid_illegal_q <= pack_illegal;
            end
            // Words leave in order, so the head address is base + 4 * drained.
            if (out_fire) begin
                out_pc_q <= out_pc_q + 32'd4;
                if (out_illegal_q && (illegal_count_q != {ILLEGAL_CNT_W{1'b1}}))
                    illegal_count_q <= illegal_count_q + ILLEGAL_CNT_W'(1);
            end
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_bits      = out_bits_q;
    assign out_illegal   = out_illegal_q;
    assign out_pc        = out_pc_q;
    assign illegal_count = illegal_count_q;

endmodule
